// File: rtl/tdpram_be_param.sv
// True dual-port byte-enable RAM with per-port write mode and a 1..3 cycle read pipeline.
// Optional collision monitor (coll_pulse, coll_cnt) is built when TDPRAM_COLLISION_MON_EN is defined.
module tdpram_be_param #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned WRITE_MODE_A = 0,
    parameter int unsigned WRITE_MODE_B = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_a,
    input  logic [DATA_W/8-1:0] wea,
    input  logic [ADDR_W-1:0]   addra,
    input  logic [DATA_W-1:0]   dina,
    output logic [DATA_W-1:0]   douta,
    output logic                douta_vld,
    input  logic                en_b,
    input  logic [DATA_W/8-1:0] web,
    input  logic [ADDR_W-1:0]   addrb,
    input  logic [DATA_W-1:0]   dinb,
    output logic [DATA_W-1:0]   doutb,
    output logic                doutb_vld
`ifdef TDPRAM_COLLISION_MON_EN
    ,
    output logic                coll_pulse,
    output logic [15:0]         coll_cnt
`endif
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        WM_WRITE_FIRST = 2'd0,
        WM_READ_FIRST  = 2'd1,
        WM_NO_CHANGE   = 2'd2
    } wmode_t;

    localparam wmode_t MODE_A = wmode_t'(WRITE_MODE_A[1:0]);
    localparam wmode_t MODE_B = wmode_t'(WRITE_MODE_B[1:0]);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 3 || (DATA_W % 8) != 0 ||
            WRITE_MODE_A > 2 || WRITE_MODE_B > 2) begin : g_bad_cfg
            $fatal(1, "tdpram_be_param: illegal configuration (READ_LATENCY=%0d DATA_W=%0d)",
                   READ_LATENCY, DATA_W);
        end
    endgenerate

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] old_a, old_b;
    logic [DATA_W-1:0] merged_a, merged_b;
    logic [DATA_W-1:0] s1_next_a, s1_next_b;
    logic              write_a, write_b;
    logic              load_a, load_b;

    logic [READ_LATENCY-1:0][DATA_W-1:0] pd_a, pd_b;
    logic [READ_LATENCY-1:0]             pv_a, pv_b;

    assign old_a   = mem[addra];
    assign old_b   = mem[addrb];
    assign write_a = en_a && (|wea);
    assign write_b = en_b && (|web);

    // Each port's merged word is built against the pre-write contents only.
    always_comb begin
        merged_a = old_a;
        merged_b = old_b;
        for (int unsigned i = 0; i < NB; i++) begin
            if (wea[i]) merged_a[8*i +: 8] = dina[8*i +: 8];
            if (web[i]) merged_b[8*i +: 8] = dinb[8*i +: 8];
        end
    end

    always_comb begin
        load_a    = 1'b0;
        s1_next_a = old_a;
        if (en_a) begin
            if (!write_a) begin
                load_a = 1'b1;
            end else begin
                case (MODE_A)
                    WM_WRITE_FIRST: begin
                        load_a    = 1'b1;
                        s1_next_a = merged_a;
                    end
                    WM_READ_FIRST: load_a = 1'b1;
                    default:       load_a = 1'b0;
                endcase
            end
        end
    end

    always_comb begin
        load_b    = 1'b0;
        s1_next_b = old_b;
        if (en_b) begin
            if (!write_b) begin
                load_b = 1'b1;
            end else begin
                case (MODE_B)
                    WM_WRITE_FIRST: begin
                        load_b    = 1'b1;
                        s1_next_b = merged_b;
                    end
                    WM_READ_FIRST: load_b = 1'b1;
                    default:       load_b = 1'b0;
                endcase
            end
        end
    end

    // Port A lanes are assigned last so they win overlapping lanes on a shared address.
    always_ff @(posedge clk) begin
        if (en_b) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (web[i]) mem[addrb][8*i +: 8] <= dinb[8*i +: 8];
            end
        end
        if (en_a) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wea[i]) mem[addra][8*i +: 8] <= dina[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pd_a <= '0;
            pv_a <= '0;
            pd_b <= '0;
            pv_b <= '0;
        end else begin
            if (load_a) pd_a[0] <= s1_next_a;
            if (load_b) pd_b[0] <= s1_next_b;
            pv_a[0] <= load_a;
            pv_b[0] <= load_b;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pd_a[i] <= pd_a[i-1];
                pv_a[i] <= pv_a[i-1];
                pd_b[i] <= pd_b[i-1];
                pv_b[i] <= pv_b[i-1];
            end
        end
    end

    assign douta     = pd_a[READ_LATENCY-1];
    assign douta_vld = pv_a[READ_LATENCY-1];
    assign doutb     = pd_b[READ_LATENCY-1];
    assign doutb_vld = pv_b[READ_LATENCY-1];

`ifdef TDPRAM_COLLISION_MON_EN
    logic collision;

    assign collision = en_a && en_b && (addra == addrb) && (write_a || write_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_pulse <= 1'b0;
            coll_cnt   <= '0;
        end else begin
            coll_pulse <= collision;
            if (collision && (coll_cnt != '1)) coll_cnt <= coll_cnt + 16'd1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && collision && (|(wea & web)))
            $warning("tdpram_be_param: overlapping write/write collision at address %0h", addra);
    end
`endif
`endif

endmodule

// File: tb/tb_tdpram_be_param.sv
// Directed bench for tdpram_be_param: three instances share stimulus, each with a different
// read latency and write-mode mix, so every mode and latency is observed from one vector set.
module tb_tdpram_be_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_a, en_b;
    logic [3:0]  wea, web;
    logic [9:0]  addra, addrb;
    logic [31:0] dina, dinb;

    logic [31:0] douta0, doutb0, douta1, doutb1, douta2, doutb2;
    logic        douta_vld0, doutb_vld0, douta_vld1, doutb_vld1, douta_vld2, doutb_vld2;
`ifdef TDPRAM_COLLISION_MON_EN
    logic        coll_pulse0, coll_pulse1, coll_pulse2;
    logic [15:0] coll_cnt0, coll_cnt1, coll_cnt2;
    int          exp_coll = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // dut0: latency 1, A write-first, B read-first
    tdpram_be_param #(.DATA_W(32), .ADDR_W(10), .READ_LATENCY(1), .WRITE_MODE_A(0), .WRITE_MODE_B(1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .wea(wea), .addra(addra), .dina(dina), .douta(douta0), .douta_vld(douta_vld0),
        .en_b(en_b), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb0), .doutb_vld(doutb_vld0)
`ifdef TDPRAM_COLLISION_MON_EN
        , .coll_pulse(coll_pulse0), .coll_cnt(coll_cnt0)
`endif
    );

    // dut1: latency 2, A no-change, B write-first
    tdpram_be_param #(.DATA_W(32), .ADDR_W(10), .READ_LATENCY(2), .WRITE_MODE_A(2), .WRITE_MODE_B(0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .wea(wea), .addra(addra), .dina(dina), .douta(douta1), .douta_vld(douta_vld1),
        .en_b(en_b), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb1), .doutb_vld(doutb_vld1)
`ifdef TDPRAM_COLLISION_MON_EN
        , .coll_pulse(coll_pulse1), .coll_cnt(coll_cnt1)
`endif
    );

    // dut2: latency 3, A read-first, B no-change
    tdpram_be_param #(.DATA_W(32), .ADDR_W(10), .READ_LATENCY(3), .WRITE_MODE_A(1), .WRITE_MODE_B(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .wea(wea), .addra(addra), .dina(dina), .douta(douta2), .douta_vld(douta_vld2),
        .en_b(en_b), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb2), .doutb_vld(doutb_vld2)
`ifdef TDPRAM_COLLISION_MON_EN
        , .coll_pulse(coll_pulse2), .coll_cnt(coll_cnt2)
`endif
    );

    function automatic logic [31:0] pat(input int unsigned i);
        return (i * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en_a = 1'b0; wea = '0; addra = '0; dina = '0;
        en_b = 1'b0; web = '0; addrb = '0; dinb = '0;
    endtask

    task automatic drive_a(input logic [3:0] we, input logic [9:0] ad, input logic [31:0] d);
        en_a = 1'b1; wea = we; addra = ad; dina = d;
    endtask

    task automatic drive_b(input logic [3:0] we, input logic [9:0] ad, input logic [31:0] d);
        en_b = 1'b1; web = we; addrb = ad; dinb = d;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #2;
        n_checks++; if ({douta0, doutb0, douta_vld0, doutb_vld0} !== 66'h0) begin n_fail++; $display("FAIL reset_dut0: got %h expected 0", {douta0, doutb0, douta_vld0, doutb_vld0}); end
        n_checks++; if ({douta1, doutb1, douta_vld1, doutb_vld1} !== 66'h0) begin n_fail++; $display("FAIL reset_dut1: got %h expected 0", {douta1, doutb1, douta_vld1, doutb_vld1}); end
        n_checks++; if ({douta2, doutb2, douta_vld2, doutb_vld2} !== 66'h0) begin n_fail++; $display("FAIL reset_dut2: got %h expected 0", {douta2, doutb2, douta_vld2, doutb_vld2}); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_byte_write();
        idle(); drive_a(4'hF, 10'd5, 32'hAABB_CCDD);
        tick();
        drive_a(4'b0101, 10'd5, 32'h1122_3344);
        tick();
        n_checks++; if (douta0 !== 32'hAA22_CC44) begin n_fail++; $display("FAIL bw_wf_douta0: got %h expected %h", douta0, 32'hAA22_CC44); end
        n_checks++; if (douta_vld0 !== 1'b1) begin n_fail++; $display("FAIL bw_wf_vld0: got %b expected 1", douta_vld0); end
        idle(); drive_b(4'h0, 10'd5, 32'h0);
        tick();
        idle();
        n_checks++; if (doutb0 !== 32'hAA22_CC44) begin n_fail++; $display("FAIL bw_doutb0: got %h expected %h", doutb0, 32'hAA22_CC44); end
        n_checks++; if (doutb_vld0 !== 1'b1) begin n_fail++; $display("FAIL bw_vldb0: got %b expected 1", doutb_vld0); end
        n_checks++; if (doutb_vld1 !== 1'b0) begin n_fail++; $display("FAIL bw_vldb1_early: got %b expected 0", doutb_vld1); end
        tick();
        n_checks++; if (doutb1 !== 32'hAA22_CC44) begin n_fail++; $display("FAIL bw_doutb1: got %h expected %h", doutb1, 32'hAA22_CC44); end
        n_checks++; if (doutb_vld1 !== 1'b1) begin n_fail++; $display("FAIL bw_vldb1: got %b expected 1", doutb_vld1); end
        n_checks++; if (doutb_vld0 !== 1'b0) begin n_fail++; $display("FAIL bw_vldb0_single: got %b expected 0", doutb_vld0); end
        n_checks++; if (doutb0 !== 32'hAA22_CC44) begin n_fail++; $display("FAIL bw_doutb0_hold: got %h expected %h", doutb0, 32'hAA22_CC44); end
        tick();
        n_checks++; if (doutb2 !== 32'hAA22_CC44) begin n_fail++; $display("FAIL bw_doutb2: got %h expected %h", doutb2, 32'hAA22_CC44); end
        n_checks++; if (doutb_vld2 !== 1'b1) begin n_fail++; $display("FAIL bw_vldb2: got %b expected 1", doutb_vld2); end
        tick();
    endtask

    task automatic test_write_modes();
        idle(); drive_a(4'hF, 10'd9, 32'h0);
        tick();
        drive_a(4'h0, 10'd5, 32'h0);
        tick();
        drive_a(4'hF, 10'd9, 32'hDEAD_BEEF);
        tick();
        idle();
        n_checks++; if (douta0 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wm_write_first_data: got %h expected %h", douta0, 32'hDEAD_BEEF); end
        n_checks++; if (douta_vld0 !== 1'b1) begin n_fail++; $display("FAIL wm_write_first_vld: got %b expected 1", douta_vld0); end
        n_checks++; if (douta1 !== 32'hAA22_CC44 || douta_vld1 !== 1'b1) begin n_fail++; $display("FAIL wm_nc_prior_read: got %h/%b expected %h/1", douta1, douta_vld1, 32'hAA22_CC44); end
        tick();
        n_checks++; if (douta1 !== 32'hAA22_CC44) begin n_fail++; $display("FAIL wm_no_change_data: got %h expected %h", douta1, 32'hAA22_CC44); end
        n_checks++; if (douta_vld1 !== 1'b0) begin n_fail++; $display("FAIL wm_no_change_vld: got %b expected 0", douta_vld1); end
        n_checks++; if (douta2 !== 32'hAA22_CC44 || douta_vld2 !== 1'b1) begin n_fail++; $display("FAIL wm_rf_prior_read: got %h/%b expected %h/1", douta2, douta_vld2, 32'hAA22_CC44); end
        tick();
        n_checks++; if (douta2 !== 32'h0) begin n_fail++; $display("FAIL wm_read_first_data: got %h expected 0", douta2); end
        n_checks++; if (douta_vld2 !== 1'b1) begin n_fail++; $display("FAIL wm_read_first_vld: got %b expected 1", douta_vld2); end
        n_checks++; if (douta1 !== 32'hAA22_CC44 || douta_vld1 !== 1'b0) begin n_fail++; $display("FAIL wm_no_change_hold: got %h/%b expected %h/0", douta1, douta_vld1, 32'hAA22_CC44); end
        tick();
    endtask

    task automatic test_ww_collision();
        idle(); drive_a(4'hF, 10'd7, 32'h5555_5555);
        tick();
        drive_a(4'b0011, 10'd7, 32'h0000_1111);
        drive_b(4'b0110, 10'd7, 32'h0022_2200);
        tick();
`ifdef TDPRAM_COLLISION_MON_EN
        exp_coll++;
        n_checks++; if (coll_pulse0 !== 1'b1) begin n_fail++; $display("FAIL ww_coll_pulse: got %b expected 1", coll_pulse0); end
        n_checks++; if (coll_cnt0 !== 16'(exp_coll)) begin n_fail++; $display("FAIL ww_coll_cnt: got %0d expected %0d", coll_cnt0, exp_coll); end
`endif
        n_checks++; if (douta0 !== 32'h5555_1111) begin n_fail++; $display("FAIL ww_a_write_first: got %h expected %h", douta0, 32'h5555_1111); end
        n_checks++; if (doutb0 !== 32'h5555_5555 || doutb_vld0 !== 1'b1) begin n_fail++; $display("FAIL ww_b_read_first: got %h/%b expected %h/1", doutb0, doutb_vld0, 32'h5555_5555); end
        idle(); drive_a(4'h0, 10'd7, 32'h0);
        tick();
        idle();
        n_checks++; if (douta0 !== 32'h5522_1111) begin n_fail++; $display("FAIL ww_readback: got %h expected %h", douta0, 32'h5522_1111); end
        n_checks++; if (doutb1 !== 32'h5522_2255 || doutb_vld1 !== 1'b1) begin n_fail++; $display("FAIL ww_b_write_first: got %h/%b expected %h/1", doutb1, doutb_vld1, 32'h5522_2255); end
`ifdef TDPRAM_COLLISION_MON_EN
        n_checks++; if (coll_pulse0 !== 1'b0) begin n_fail++; $display("FAIL ww_coll_pulse_single: got %b expected 0", coll_pulse0); end
`endif
        tick();
        tick();
    endtask

    task automatic test_rw_collision();
        idle(); drive_a(4'hF, 10'd3, 32'h1);
        tick();
        drive_a(4'h0, 10'd3, 32'h0);
        drive_b(4'hF, 10'd3, 32'h2);
        tick();
`ifdef TDPRAM_COLLISION_MON_EN
        exp_coll++;
        n_checks++; if (coll_cnt0 !== 16'(exp_coll)) begin n_fail++; $display("FAIL rw_coll_cnt: got %0d expected %0d", coll_cnt0, exp_coll); end
`endif
        n_checks++; if (douta0 !== 32'h1 || douta_vld0 !== 1'b1) begin n_fail++; $display("FAIL rw_old_word: got %h/%b expected 1/1", douta0, douta_vld0); end
        idle(); drive_a(4'h0, 10'd3, 32'h0);
        tick();
        idle();
        n_checks++; if (douta0 !== 32'h2) begin n_fail++; $display("FAIL rw_new_word: got %h expected 2", douta0); end
        n_checks++; if (douta1 !== 32'h1 || douta_vld1 !== 1'b1) begin n_fail++; $display("FAIL rw_old_word_l2: got %h/%b expected 1/1", douta1, douta_vld1); end
        tick();
        tick();
    endtask

    task automatic test_reset_inflight();
        idle(); drive_a(4'h0, 10'd5, 32'h0); drive_b(4'h0, 10'd9, 32'h0);
        tick();
        tick();
        tick();
        idle();
        n_checks++; if (douta2 !== 32'hAA22_CC44 || douta_vld2 !== 1'b1) begin n_fail++; $display("FAIL rst_pre_douta2: got %h/%b expected %h/1", douta2, douta_vld2, 32'hAA22_CC44); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({douta2, doutb2, douta_vld2, doutb_vld2} !== 66'h0) begin n_fail++; $display("FAIL rst_async_dut2: got %h expected 0", {douta2, doutb2, douta_vld2, doutb_vld2}); end
        n_checks++; if ({douta1, doutb1, douta_vld1, doutb_vld1} !== 66'h0) begin n_fail++; $display("FAIL rst_async_dut1: got %h expected 0", {douta1, doutb1, douta_vld1, doutb_vld1}); end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if ({douta_vld0, doutb_vld0, douta_vld1, doutb_vld1, douta_vld2, doutb_vld2} !== 6'b0) begin
                n_fail++;
                $display("FAIL rst_no_vld_cycle%0d: got %b expected 000000", c,
                         {douta_vld0, doutb_vld0, douta_vld1, doutb_vld1, douta_vld2, doutb_vld2});
            end
        end
    endtask

    task automatic test_back_to_back();
        int vld_count = 0;
        idle();
        for (int unsigned i = 0; i < 1024; i++) begin
            drive_a(4'hF, 10'(i), pat(i));
            tick();
        end
        idle();
        tick();
        tick();
        for (int unsigned c = 0; c < 1026; c++) begin
            if (c < 1024) drive_b(4'h0, 10'(c), 32'h0);
            else idle();
            tick();
            if (doutb_vld1 === 1'b1) vld_count++;
            n_checks++;
            if (c == 0 || c == 1025) begin
                if (doutb_vld1 !== 1'b0) begin n_fail++; $display("FAIL stream_vld_edge_c%0d: got %b expected 0", c, doutb_vld1); end
            end else if (doutb_vld1 !== 1'b1 || doutb1 !== pat(c - 1)) begin
                n_fail++;
                $display("FAIL stream_word%0d: got %h/%b expected %h/1", c - 1, doutb1, doutb_vld1, pat(c - 1));
            end
        end
        n_checks++; if (vld_count != 1024) begin n_fail++; $display("FAIL stream_vld_count: got %0d expected 1024", vld_count); end
    endtask

    initial begin
        idle();
        test_reset();
        test_byte_write();
        test_write_modes();
        test_ww_collision();
        test_rw_collision();
        test_reset_inflight();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
